// File: rtl/cpu_pipe_pkg.sv
// Shared constants for the processor's inter-stage pipeline registers:
// per-boundary control/data widths and the control-field bit layout.
package cpu_pipe_pkg;

    // Pipeline boundaries that instantiate a pipe_stage_reg.
    typedef enum logic [1:0] {
        BND_IF_ID,
        BND_ID_EX,
        BND_EX_MEM,
        BND_MEM_WB
    } boundary_e;

    // Per-boundary payload widths.
    localparam int unsigned CTRL_W_IF_ID  = 1;
    localparam int unsigned DATA_W_IF_ID  = 64;
    localparam int unsigned CTRL_W_ID_EX  = 12;
    localparam int unsigned DATA_W_ID_EX  = 154;
    localparam int unsigned CTRL_W_EX_MEM = 5;
    localparam int unsigned DATA_W_EX_MEM = 106;
    localparam int unsigned CTRL_W_MEM_WB = 2;
    localparam int unsigned DATA_W_MEM_WB = 69;

    // Control-field bit positions (ID/EX layout); bits 10..11 are spare.
    localparam int unsigned REGDST   = 0;
    localparam int unsigned ALUSRC   = 1;
    localparam int unsigned MEMTOREG = 2;
    localparam int unsigned REGWRITE = 3;
    localparam int unsigned MEMREAD  = 4;
    localparam int unsigned MEMWRITE = 5;
    localparam int unsigned BRANCH   = 6;
    localparam int unsigned ALUOP_LO = 7;
    localparam int unsigned ALUOP_HI = 9;

    // Control width for a given boundary.
    function automatic int unsigned ctrl_w_of(boundary_e b);
        case (b)
            BND_IF_ID:  return CTRL_W_IF_ID;
            BND_ID_EX:  return CTRL_W_ID_EX;
            BND_EX_MEM: return CTRL_W_EX_MEM;
            default:    return CTRL_W_MEM_WB;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid bit, killable control field, persistent data field.
// Priority: RST > flush > freeze (hit=0) > load > clear > hold.
module pipe_slot
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_W_ID_EX,
    parameter int unsigned DATA_W = DATA_W_ID_EX
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              hit,
    input  logic              flush,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              v,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic              v_q, v_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Next-state selection for this slot.
    always_comb begin
        v_d    = v_q;
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (RST) begin
            v_d    = 1'b0;
            ctrl_d = '0;
            data_d = '0;
        end else if (flush) begin
            v_d    = 1'b0;
            ctrl_d = '0;
        end else if (hit) begin
            if (load) begin
                v_d    = 1'b1;
                ctrl_d = ld_ctrl;
                data_d = ld_data;
            end else if (clear) begin
                v_d    = 1'b0;
                ctrl_d = '0;
            end
        end
    end

    // Slot registers update on the falling clock edge.
    always_ff @(negedge CLK) begin
        v_q    <= v_d;
        ctrl_q <= ctrl_d;
        data_q <= data_d;
    end

    // Expose the stored state.
    always_comb begin
        v    = v_q;
        ctrl = ctrl_q;
        data = data_q;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready flow control,
// bubble collapsing, synchronous flush and cache-miss freeze (hit=0).
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_W_ID_EX,
    parameter int unsigned DATA_W = DATA_W_ID_EX,
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         hit,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [CNT_W-1:0]             bubble_cnt
`endif
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned LAST  = DEPTH - 1;

    logic [DEPTH-1:0]  slot_v;
    logic [CTRL_W-1:0] slot_ctrl [DEPTH];
    logic [DATA_W-1:0] slot_data [DEPTH];

    logic [DEPTH-1:0]  adv;
    logic [DEPTH-1:0]  slot_load;
    logic [DEPTH-1:0]  slot_clear;
    logic [CTRL_W-1:0] src_ctrl [DEPTH];
    logic [DATA_W-1:0] src_data [DEPTH];

    logic              accept;
    logic [OCC_W-1:0]  occ_q, occ_d;

    // Advance chain, evaluated from the last slot back so each slot sees
    // whether the slot ahead of it is vacating this cycle.
    always_comb begin
        int unsigned idx;
        adv = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = LAST - k;
            if (idx == LAST) begin
                adv[idx] = slot_v[idx] & out_ready;
            end else begin
                adv[idx] = slot_v[idx] & (~slot_v[idx+1] | adv[idx+1]);
            end
        end
    end

    // Upstream handshake.
    always_comb begin
        in_ready = hit & ~flush & ~RST & (~slot_v[0] | adv[0]);
        accept   = in_valid & in_ready;
    end

    // Per-slot load source and load/clear strobes.
    always_comb begin
        slot_load  = '0;
        slot_clear = '0;
        src_ctrl   = '{default: '0};
        src_data   = '{default: '0};
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i == 0) begin
                slot_load[i] = accept;
                src_ctrl[i]  = in_ctrl;
                src_data[i]  = in_data;
            end else begin
                slot_load[i] = adv[i-1];
                src_ctrl[i]  = slot_ctrl[i-1];
                src_data[i]  = slot_data[i-1];
            end
            slot_clear[i] = adv[i] & ~slot_load[i];
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        pipe_slot #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_slot (
            .CLK     (CLK),
            .RST     (RST),
            .hit     (hit),
            .flush   (flush),
            .load    (slot_load[gi]),
            .clear   (slot_clear[gi]),
            .ld_ctrl (src_ctrl[gi]),
            .ld_data (src_data[gi]),
            .v       (slot_v[gi]),
            .ctrl    (slot_ctrl[gi]),
            .data    (slot_data[gi])
        );
    end

    // Occupancy tracks the popcount of the valid bits incrementally:
    // +1 on accept, -1 when the last slot is consumed.
    always_comb begin
        occ_d = occ_q;
        if (RST || flush) begin
            occ_d = '0;
        end else if (hit) begin
            occ_d = occ_q + OCC_W'(accept) - OCC_W'(adv[LAST]);
        end
    end

    // Occupancy register.
    always_ff @(negedge CLK) begin
        occ_q <= occ_d;
    end

    // Downstream view; control is gated so an empty slot never shows stale bits.
    always_comb begin
        out_valid = slot_v[LAST];
        out_ctrl  = slot_v[LAST] ? slot_ctrl[LAST] : '0;
        out_data  = slot_data[LAST];
        occupancy = occ_q;
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating stall/bubble counters; stalls count even while frozen.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (RST) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (in_valid && !in_ready && !flush && !(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (hit && !slot_v[LAST] && !(&bubble_cnt_q)) begin
                bubble_cnt_d = bubble_cnt_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(negedge CLK) begin
        stall_cnt_q  <= stall_cnt_d;
        bubble_cnt_q <= bubble_cnt_d;
    end

    // Counter outputs.
    always_comb begin
        stall_cnt  = stall_cnt_q;
        bubble_cnt = bubble_cnt_q;
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (DEPTH=3). The reference model tracks
// in-flight instructions as a queue of slot positions; a monitor checks every
// consumed instruction against a scoreboard of accepted payloads.
module tb_pipe_stage_reg;

    localparam int unsigned CW      = 12;
    localparam int unsigned DW      = 154;
    localparam int unsigned T_DEPTH = 3;
    localparam int unsigned OW      = $clog2(T_DEPTH + 1);

    logic          CLK;
    logic          RST;
    logic          hit;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [OW-1:0] occupancy;
`ifdef PIPE_PERF_CNT_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   bubble_cnt;
    int            exp_stall;
    int            exp_bubble;
`endif

    pipe_stage_reg #(
        .CTRL_W (CW),
        .DATA_W (DW),
        .DEPTH  (T_DEPTH),
        .CNT_W  (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .hit       (hit),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    int                    checks = 0;
    int                    errors = 0;
    logic                  armed  = 1'b0;
    logic                  prev_rst = 1'b0;
    int                    m_q[$];
    logic [CW+DW-1:0]      sb_q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(DW); i += 32) begin
            r = (r << 32) | DW'($urandom);
        end
        return r;
    endfunction

    // One clock: drive after the falling edge, check at the rising edge,
    // advance the model at the next falling edge.
    task automatic step(input logic r, input logic f, input logic h, input logic iv,
                        input logic orr, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        output logic acc);
        int   nq[$];
        int   lim;
        logic rdy;
        logic exp_ov;
        RST = r; flush = f; hit = h; in_valid = iv; out_ready = orr;
        in_ctrl = c; in_data = d;
        @(posedge CLK);
        exp_ov = (m_q.size() > 0) && (m_q[0] == int'(T_DEPTH) - 1);
        nq = m_q;
        if (h && !f && !r) begin
            if (exp_ov && orr) void'(nq.pop_front());
            for (int k = 0; k < nq.size(); k++) begin
                lim = (k == 0) ? int'(T_DEPTH) - 1 : nq[k-1] - 1;
                if (nq[k] < lim) nq[k] = nq[k] + 1;
            end
        end
        rdy = h && !f && !r && (nq.size() == 0 || nq[nq.size()-1] > 0);
        acc = iv && rdy;
        if (armed) begin
            check("in_ready", 256'(in_ready), 256'(rdy));
            check("out_valid", 256'(out_valid), 256'(exp_ov));
            check("occupancy", 256'(occupancy), 256'(m_q.size()));
            if (!exp_ov) check("out_ctrl_gated", 256'(out_ctrl), 256'(0));
            if (prev_rst) check("out_data_after_rst", 256'(out_data), 256'(0));
`ifdef PIPE_PERF_CNT_EN
            check("stall_cnt", 256'(stall_cnt), 256'(exp_stall));
            check("bubble_cnt", 256'(bubble_cnt), 256'(exp_bubble));
`endif
        end
        @(negedge CLK);
        if (r || f) begin
            m_q.delete();
            sb_q.delete();
        end else begin
            m_q = nq;
            if (acc) begin
                m_q.push_back(0);
                sb_q.push_back({c, d});
            end
        end
`ifdef PIPE_PERF_CNT_EN
        if (r) begin
            exp_stall  = 0;
            exp_bubble = 0;
        end else begin
            if (iv && !rdy && !f && exp_stall < 65535) exp_stall++;
            if (h && !exp_ov && exp_bubble < 65535) exp_bubble++;
        end
`endif
        prev_rst = r;
        armed = 1'b1;
        #1;
    endtask

    task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d, input logic orr);
        logic a;
        int   n;
        a = 1'b0;
        n = 0;
        while (!a && n < 20) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, orr, c, d, a);
            n++;
        end
        check("send_accepted", 256'(a), 256'(1));
    endtask

    task automatic idle(input int n, input logic orr);
        logic a;
        repeat (n) step(1'b0, 1'b0, 1'b1, 1'b0, orr, '0, '0, a);
    endtask

    // Monitor: every consumed instruction must be the oldest accepted one.
    initial begin
        logic [CW+DW-1:0] exp;
        forever begin
            @(posedge CLK);
            if (armed && out_valid === 1'b1 && out_ready && hit && !flush && !RST) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_output: got data %0h expected no valid output at %0t",
                             out_data, $time);
                end else begin
                    exp = sb_q.pop_front();
                    check("out_ctrl", 256'(out_ctrl), 256'(exp[CW+DW-1:DW]));
                    check("out_data", 256'(out_data), 256'(exp[DW-1:0]));
                end
            end
        end
    end

    initial begin
        logic a;
        int   n;
`ifdef PIPE_PERF_CNT_EN
        exp_stall  = 0;
        exp_bubble = 0;
`endif
        // Reset.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, a);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, a);

        // Back-to-back stream, no stalls.
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h3A5, DW'(i), a);
            check("stream_accept", 256'(a), 256'(1));
        end
        idle(4, 1'b1);

        // Fill with downstream blocked; the 4th item waits upstream.
        for (int i = 0; i < 3; i++) send(CW'(12'h100 + i), DW'(100 + i), 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h103, DW'(103), a);
        send(12'h103, DW'(103), 1'b1);
        idle(5, 1'b1);

        // Flush a full pipeline while input is offered.
        for (int i = 0; i < 3; i++) send(CW'(12'h200 + i), DW'(200 + i), 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h2FF, DW'(299), a);
        idle(2, 1'b1);

        // Freeze mid-stream for five cycles.
        for (int i = 0; i < 3; i++) send(CW'(12'h300 + i), DW'(300 + i), 1'b1);
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h3FF, DW'(399), a);
        for (int i = 3; i < 6; i++) send(CW'(12'h300 + i), DW'(300 + i), 1'b1);
        idle(4, 1'b1);

        // Reset together with flush and input while full.
        for (int i = 0; i < 3; i++) send(CW'(12'h400 + i), rand_data(), 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h4FF, rand_data(), a);
        idle(1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h500, DW'(500), a);
        idle(1, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4,
                 $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 60, CW'($urandom), rand_data(), a);
        end

        // Drain with a bounded budget.
        n = 0;
        while (m_q.size() > 0 && n < 20) begin
            idle(1, 1'b1);
            n++;
        end
        idle(1, 1'b1);
        check("drain_empty", 256'(sb_q.size()), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline register for the processor's inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It generalises the fixed ID/EX latch into DEPTH slots, each holding a split payload: control bits that must be killed on flush, and data bits that need not be. It adds valid/ready flow control with bubble collapsing, a synchronous flush that inserts bubbles, and a global freeze on cache miss (hit=0). It sits between hazard/control logic and stage datapaths and is instantiated once per boundary.

Parameters:
CTRL_W, 12, control-field width (regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch, aluOp…); zeroed on flush/reset
DATA_W, 154, data-field width (operands, immediate, rt/rd, funct, nextPc); never cleared
DEPTH, 1, number of slots, legal 1..4; DEPTH=1 is a drop-in ID/EX latch
CNT_W, 16, perf-counter width (optional feature only)

Ports:
CLK  in  1  clock; all state updates on negedge CLK
RST  in  1  synchronous active-high reset, sampled on negedge CLK
hit  in  1  global enable (cache hit); 0 freezes all state
flush  in  1  kill all slots (branch taken / hazard squash)
in_valid  in  1  upstream has an instruction
in_ready  out  1  slot 0 can accept this cycle
in_ctrl  in  CTRL_W  control field
in_data  in  DATA_W  data field
out_valid  out  1  last slot holds a valid instruction
out_ready  in  1  downstream consumes this cycle
out_ctrl  out  CTRL_W  last-slot control, forced 0 when out_valid=0
out_data  out  DATA_W  last-slot data (don't-care when out_valid=0)
occupancy  out  $clog2(DEPTH+1)  count of valid slots

Behaviour:
- Slots 0..DEPTH-1; slot DEPTH-1 drives outputs. Each slot: v, ctrl, data registers.
- Advance rule (combinational, last slot first): adv[DEPTH-1] = v[DEPTH-1] & out_ready; adv[i] = v[i] & (!v[i+1] | adv[i+1]). Slot i loads from slot i-1 (or from input for i=0) when its vacancy condition holds; bubbles collapse.
- in_ready = hit & !flush & !RST & (!v[0] | adv[0]). Accept = in_valid & in_ready.
- A slot that empties without refill clears v and loads ctrl=0; data holds.
- Latency: with no stalls, input accepted at negedge n appears at outputs after negedge n+DEPTH-1 (DEPTH=1: visible right after the capturing edge). Throughput 1/cycle.
- hit=0: no register changes (v, ctrl, data, counters held except stall counter); in_ready=0; out_valid/out_ctrl/out_data remain driven from held state, and downstream must not treat out_ready as consumed.
- flush=1 (with RST=0): all v←0, all ctrl←0, input not accepted. This takes effect regardless of hit; flush overrides a frozen stage.
- RST=1: all v←0, ctrl←0, data←0, occupancy=0, counters←0; RST overrides flush and hit. Mid-stream reset discards every slot.
- out_ctrl = v[DEPTH-1] ? ctrl[DEPTH-1] : 0 (combinational gate, so consumers never see stale regWrite/memWrite).
- Simultaneous accept and consume on a full pipeline: legal, occupancy unchanged.
- occupancy is the registered popcount of v. It never exceeds DEPTH.

Optional Feature:
PIPE_PERF_CNT_EN: when defined, adds outputs stall_cnt[CNT_W] (increments each cycle with in_valid & !in_ready & !flush, including hit=0) and bubble_cnt[CNT_W] (increments each cycle with hit & !out_valid). Both counters saturate at all-ones and clear on RST. When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pipe_pkg: CTRL_W/DATA_W per-boundary constants, and bit-index localparams for the control-field layout (REGDST, ALUSRC, MEMTOREG, REGWRITE, MEMREAD, MEMWRITE, BRANCH, ALUOP[2:0]).
- One natural sub-module, pipe_slot, holding a single slot's v/ctrl/data with load/clear/hold controls. The top module generates DEPTH instances and the advance chain.

Test Plan:
- DEPTH=1, hit=1, out_ready=1: stream ctrl=0x3A5, data=1..5 → out_ctrl=0x3A5 and out_data 1..5 on consecutive cycles, in_ready constantly 1.
- DEPTH=3, out_ready=0, push 4 items → occupancy 1,2,3 then in_ready=0. The 4th item is held upstream. Raising out_ready drains items in order with no loss.
- DEPTH=2 full, flush=1 for one cycle with in_valid=1 → next cycle out_valid=0, out_ctrl=0, occupancy=0, and the input is not accepted.
- hit=0 for 5 cycles mid-stream with out_ready=1 → all outputs and occupancy frozen, in_ready=0. After hit=1, the sequence resumes without duplication.
- RST asserted together with flush and in_valid while full → next cycle out_valid=0, occupancy=0, out_data=0. With PIPE_PERF_CNT_EN: stall_cnt=0, and hit=0 for 3 cycles with in_valid=1 gives stall_cnt=3.
